// File: rtl/segment_descriptor_loader_pkg.sv
// Shared types for the segment descriptor loader: target/fault encodings,
// descriptor field offsets and the loader state enum.
package segment_descriptor_loader_pkg;

    typedef enum logic [2:0] {
        SEG_CS = 3'd0,
        SEG_SS = 3'd1,
        SEG_DS = 3'd2,
        SEG_ES = 3'd3,
        SEG_FS = 3'd4,
        SEG_GS = 3'd5
    } segment_target_t;

    typedef enum logic [2:0] {
        FAULT_NONE    = 3'd0,
        FAULT_GP      = 3'd1,
        FAULT_NP      = 3'd2,
        FAULT_STACK   = 3'd3,
        FAULT_TIMEOUT = 3'd4
    } fault_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ_LO,
        ST_READ_HI,
        ST_VALIDATE,
        ST_COMMIT,
        ST_FAULT
    } loader_state_t;

    // Bit offsets within the assembled 64-bit descriptor {high dword, low dword}.
    localparam int DESC_TYPE_LSB = 40;
    localparam int DESC_S_BIT    = 44;
    localparam int DESC_P_BIT    = 47;

    // Bits within the 4-bit type field.
    localparam int TYPE_CODE_BIT = 3;
    localparam int TYPE_RW_BIT   = 1;

    // One-hot write enable for a segment target; unknown targets enable nothing.
    function automatic logic [5:0] target_onehot(input logic [2:0] target);
        logic [5:0] onehot;
        onehot = 6'b000000;
        case (target)
            3'd0:    onehot = 6'b000001;
            3'd1:    onehot = 6'b000010;
            3'd2:    onehot = 6'b000100;
            3'd3:    onehot = 6'b001000;
            3'd4:    onehot = 6'b010000;
            3'd5:    onehot = 6'b100000;
            default: onehot = 6'b000000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/segment_descriptor_loader_decode.sv
// Pulls the type, S and P fields out of an assembled 64-bit segment descriptor.
module segment_descriptor_loader_decode
    import segment_descriptor_loader_pkg::*;
(
    input  logic [63:0] descriptor,
    output logic [3:0]  desc_type,
    output logic        desc_s,
    output logic        desc_p
);

    // Base, limit, DPL and flag bits are carried through to the segment
    // register untouched; only the access-rights fields matter here.
    logic decode_unused;

    assign desc_type     = descriptor[DESC_TYPE_LSB +: 4];
    assign desc_s        = descriptor[DESC_S_BIT];
    assign desc_p        = descriptor[DESC_P_BIT];
    assign decode_unused = ^{descriptor[39:0], descriptor[46:45], descriptor[63:48]};

endmodule

// File: rtl/segment_descriptor_loader.sv
// Segment-register load sequencer: fetches an 8-byte descriptor from the GDT
// or LDT, validates it and commits selector + descriptor to one segment block.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | ready for a load; selector/target latched on request
//   ST_CHECK    | null-selector handling and table limit check
//   ST_READ_LO  | reading descriptor low dword
//   ST_READ_HI  | reading descriptor high dword
//   ST_VALIDATE | S/type/present checks against the target register
//   ST_COMMIT   | one-cycle write to the target segment register, load_done
//   ST_FAULT    | one-cycle load_fault with code and error code
module segment_descriptor_loader
    import segment_descriptor_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_request,
    output logic        load_ready,
    input  logic [15:0] load_selector,
    input  logic [2:0]  load_target,
    input  logic [31:0] gdtr_base,
    input  logic [15:0] gdtr_limit,
    input  logic [31:0] ldtr_base,
    input  logic [15:0] ldtr_limit,
    output logic        mem_read_request,
    output logic [31:0] mem_address,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data,
    output logic [5:0]  segment_write_enable,
    output logic [15:0] selector_write_data,
    output logic [63:0] descriptor_write_data,
    output logic        load_done,
    output logic        load_fault,
    output logic [2:0]  fault_code,
    output logic [15:0] fault_error_code
);

    // Wait counter is 16 bits wide; larger timeouts saturate.
    localparam int unsigned TIMEOUT_CLAMPED = (TIMEOUT_CYCLES > 65535) ? 65535 : TIMEOUT_CYCLES;
    localparam logic [15:0] TIMEOUT_LOAD    = 16'(TIMEOUT_CLAMPED);
    localparam bit          TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);

    loader_state_t   state_q, state_d;
    fault_code_t     fault_q, fault_d;
    logic [15:0]     selector_q;
    segment_target_t target_q;
    logic [31:0]     lo_q, hi_q;
    logic [15:0]     wait_q;

    logic [12:0]     index_w;
    logic            ti_w;
    logic            null_selector;
    logic [31:0]     table_base;
    logic [15:0]     table_limit;
    logic            over_limit;
    logic [31:0]     lo_address, hi_address;
    logic            timeout_hit;
    logic [3:0]      desc_type;
    logic            desc_s, desc_p;
    logic            type_ok;

    assign index_w       = selector_q[15:3];
    assign ti_w          = selector_q[2];
    assign null_selector = (index_w == 13'd0) && !ti_w;
    assign table_base    = ti_w ? ldtr_base  : gdtr_base;
    assign table_limit   = ti_w ? ldtr_limit : gdtr_limit;
    // Last byte of the descriptor must lie inside the table; 17 bits so index 0x1FFF cannot wrap.
    assign over_limit    = {1'b0, index_w, 3'b111} > {1'b0, table_limit};
    assign lo_address    = table_base + {16'h0000, index_w, 3'b000};
    assign hi_address    = lo_address + 32'd4;
    // The counter holds the number of wait cycles left including the current one.
    assign timeout_hit   = TIMEOUT_ENABLED && (wait_q == 16'd1) && !mem_ready;

    segment_descriptor_loader_decode u_decode (
        .descriptor (
            {hi_q, lo_q}
        ),
        .desc_type  (desc_type),
        .desc_s     (desc_s),
        .desc_p     (desc_p)
    );

    // Register state, latched request, fetched dwords and the per-read wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fault_q    <= FAULT_NONE;
            selector_q <= 16'h0000;
            target_q   <= SEG_CS;
            lo_q       <= 32'h0000_0000;
            hi_q       <= 32'h0000_0000;
            wait_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_q == ST_IDLE && load_request) begin
                selector_q <= load_selector;
                target_q   <= segment_target_t'(load_target);
                lo_q       <= 32'h0000_0000;
                hi_q       <= 32'h0000_0000;
            end
            if (state_q == ST_READ_LO && mem_ready) lo_q <= mem_read_data;
            if (state_q == ST_READ_HI && mem_ready) hi_q <= mem_read_data;
            if (state_d != state_q)   wait_q <= TIMEOUT_LOAD;
            else if (wait_q != 16'd0) wait_q <= wait_q - 16'd1;
        end
    end

    // Descriptor type acceptable for the requested segment register.
    always_comb begin
        type_ok = 1'b0;
        case (target_q)
            SEG_CS:  type_ok = desc_type[TYPE_CODE_BIT];
            SEG_SS:  type_ok = !desc_type[TYPE_CODE_BIT] && desc_type[TYPE_RW_BIT];
            default: type_ok = !desc_type[TYPE_CODE_BIT] || desc_type[TYPE_RW_BIT];
        endcase
    end

    // Next-state, fault classification and state-decoded outputs.
    always_comb begin
        state_d               = state_q;
        fault_d               = fault_q;
        load_ready            = 1'b0;
        mem_read_request      = 1'b0;
        mem_address           = 32'h0000_0000;
        segment_write_enable  = 6'b000000;
        selector_write_data   = 16'h0000;
        descriptor_write_data = 64'h0;
        load_done             = 1'b0;
        load_fault            = 1'b0;
        fault_code            = FAULT_NONE;
        fault_error_code      = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                fault_d    = FAULT_NONE;
                if (load_request) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (null_selector) begin
                    if (target_q == SEG_CS || target_q == SEG_SS) begin
                        state_d = ST_FAULT;
                        fault_d = FAULT_GP;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else if (over_limit) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_GP;
                end else begin
                    state_d = ST_READ_LO;
                end
            end
            ST_READ_LO: begin
                mem_read_request = 1'b1;
                mem_address      = lo_address;
                if (mem_ready) begin
                    state_d = ST_READ_HI;
                end else if (timeout_hit) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_READ_HI: begin
                mem_read_request = 1'b1;
                mem_address      = hi_address;
                if (mem_ready) begin
                    state_d = ST_VALIDATE;
                end else if (timeout_hit) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_VALIDATE: begin
                if (!desc_s || !type_ok) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_GP;
                end else if (!desc_p) begin
                    state_d = ST_FAULT;
                    fault_d = (target_q == SEG_SS) ? FAULT_STACK : FAULT_NP;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                segment_write_enable  = target_onehot(target_q);
                selector_write_data   = selector_q;
                descriptor_write_data = {hi_q, lo_q};
                load_done             = 1'b1;
                state_d               = ST_IDLE;
            end
            ST_FAULT: begin
                load_fault       = 1'b1;
                fault_code       = fault_q;
                // A null selector has index and TI clear, so this is 0 for it.
                fault_error_code = {selector_q[15:2], 2'b00};
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_segment_descriptor_loader.sv
// Scoreboard bench for segment_descriptor_loader: directed cases plus random
// loads checked against a rule-level reference model.
module tb_segment_descriptor_loader;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_request;
    logic        load_ready;
    logic [15:0] load_selector;
    logic [2:0]  load_target;
    logic [31:0] gdtr_base, ldtr_base;
    logic [15:0] gdtr_limit, ldtr_limit;
    logic        mem_read_request;
    logic [31:0] mem_address;
    logic        mem_ready;
    logic [31:0] mem_read_data;
    logic [5:0]  segment_write_enable;
    logic [15:0] selector_write_data;
    logic [63:0] descriptor_write_data;
    logic        load_done, load_fault;
    logic [2:0]  fault_code;
    logic [15:0] fault_error_code;

    segment_descriptor_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .load_request          (load_request),
        .load_ready            (load_ready),
        .load_selector         (load_selector),
        .load_target           (load_target),
        .gdtr_base             (gdtr_base),
        .gdtr_limit            (gdtr_limit),
        .ldtr_base             (ldtr_base),
        .ldtr_limit            (ldtr_limit),
        .mem_read_request      (mem_read_request),
        .mem_address           (mem_address),
        .mem_ready             (mem_ready),
        .mem_read_data         (mem_read_data),
        .segment_write_enable  (segment_write_enable),
        .selector_write_data   (selector_write_data),
        .descriptor_write_data (descriptor_write_data),
        .load_done             (load_done),
        .load_fault            (load_fault),
        .fault_code            (fault_code),
        .fault_error_code      (fault_error_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_fault;
        logic [5:0]  we;
        logic [15:0] sel;
        logic [63:0] desc;
        logic [2:0]  code;
        logic [15:0] err;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          lat_q[$];
    logic [31:0] mem [logic [31:0]];

    int checks = 0;
    int passed = 0;
    int cycle_cnt = 0;
    bit reads_allowed = 1'b0;
    bit spurious = 1'b0;

    always @(posedge clock) cycle_cnt++;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        checks++;
        $display("FAIL %s: got %h, expected nothing", name, act);
    endtask

    // Memory slave: per-read latency from lat_q; optional stray mem_ready outside reads.
    initial begin
        int wait_cnt;
        int cur_lat;
        bit in_read;
        wait_cnt = 0; cur_lat = 0; in_read = 0;
        mem_ready = 1'b0; mem_read_data = 32'h0;
        forever begin
            @(negedge clock);
            if (mem_read_request && !reset) begin
                if (!in_read) begin
                    in_read = 1; wait_cnt = 0;
                    cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                end
                if (wait_cnt >= cur_lat) begin
                    mem_ready = 1'b1; mem_read_data = mem_rd(mem_address); in_read = 0;
                end else begin
                    mem_ready = 1'b0; mem_read_data = $urandom; wait_cnt++;
                end
            end else begin
                in_read = 0;
                mem_ready = spurious && ($urandom_range(0, 3) == 0);
                mem_read_data = $urandom;
            end
        end
    end

    // Monitor: read addresses and commit/fault pulses against the scoreboard queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock); #1;
            if (!reset) begin
                if (mem_read_request && !reads_allowed) flag("unexpected_read_request", mem_address);
                if (mem_read_request && mem_ready) begin
                    if (addr_q.size() == 0) flag("unexpected_read", mem_address);
                    else check("read_address", mem_address, addr_q.pop_front());
                end
                if (load_done || load_fault || segment_write_enable != 6'b0) begin
                    if (exp_q.size() == 0) begin
                        flag("unexpected_pulse", {load_done, load_fault, segment_write_enable});
                    end else begin
                        e = exp_q.pop_front();
                        check("load_done", load_done, !e.is_fault);
                        check("load_fault", load_fault, e.is_fault);
                        check("write_enable", segment_write_enable, e.we);
                        if (e.is_fault) begin
                            check("fault_code", fault_code, e.code);
                            check("fault_error_code", fault_error_code, e.err);
                        end else begin
                            check("selector_write", selector_write_data, e.sel);
                            check("descriptor_write", descriptor_write_data, e.desc);
                        end
                        if (e.lat >= 0) check("latency", cycle_cnt - e.issue, e.lat);
                    end
                end
            end
        end
    end

    // Reference model: derives the outcome from the descriptor-table rules and
    // queues the memory latencies and read addresses the load will produce.
    task automatic model(input logic [15:0] sel, input int tgt, input int lat_lo,
                         input int lat_hi, output exp_t e, output bit reads);
        int          idx;
        logic [15:0] lim;
        logic [31:0] base, a_lo, a_hi, lo, hi;
        logic [3:0]  typ;
        bit          ok;
        idx = int'(sel[15:3]);
        e.is_fault = 0; e.we = 0; e.sel = sel; e.desc = 0; e.code = 0;
        e.err = {sel[15:2], 2'b00}; e.lat = -1; e.issue = 0;
        reads = 0;
        if (idx == 0 && !sel[2]) begin
            if (tgt < 2) begin e.is_fault = 1; e.code = 3'd1; e.err = 16'h0; end
            else e.we = 6'(1 << tgt);
            return;
        end
        lim = sel[2] ? ldtr_limit : gdtr_limit;
        if (idx * 8 + 7 > int'(lim)) begin e.is_fault = 1; e.code = 3'd1; return; end
        base = sel[2] ? ldtr_base : gdtr_base;
        a_lo = base + 32'(idx * 8);
        a_hi = a_lo + 32'd4;
        reads = 1;
        lat_q.push_back(lat_lo);
        if (lat_lo >= TMO) begin e.is_fault = 1; e.code = 3'd4; return; end
        addr_q.push_back(a_lo);
        lat_q.push_back(lat_hi);
        if (lat_hi >= TMO) begin e.is_fault = 1; e.code = 3'd4; return; end
        addr_q.push_back(a_hi);
        lo = mem_rd(a_lo); hi = mem_rd(a_hi);
        typ = hi[11:8];
        if (tgt == 0)      ok = typ[3];
        else if (tgt == 1) ok = !typ[3] && typ[1];
        else               ok = !typ[3] || typ[1];
        if (!hi[12] || !ok) begin e.is_fault = 1; e.code = 3'd1; return; end
        if (!hi[15]) begin e.is_fault = 1; e.code = (tgt == 1) ? 3'd3 : 3'd2; return; end
        e.we = 6'(1 << tgt); e.desc = {hi, lo}; e.lat = 5 + lat_lo + lat_hi;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!load_ready && $urandom_range(0, 2) == 0) begin
                load_request = 1'b1; load_selector = 16'($urandom); load_target = 3'($urandom_range(0, 5));
            end else begin
                load_request = 1'b0;
            end
            if (exp_q.size() == 0 && load_ready) begin done = 1; break; end
        end
        if (!done) flag(name, 64'(exp_q.size()));
        load_request = 1'b0;
        reads_allowed = 0;
    endtask

    task automatic run_txn(input logic [15:0] sel, input int tgt, input int lat_lo, input int lat_hi);
        exp_t e;
        bit   reads;
        model(sel, tgt, lat_lo, lat_hi, e, reads);
        reads_allowed = reads;
        @(negedge clock);
        load_selector = sel; load_target = 3'(tgt); load_request = 1'b1;
        e.issue = cycle_cnt;
        exp_q.push_back(e);
        wait_idle("txn_completion");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_load_ready"}, load_ready, 1'b1);
        check({tag, "_mem_read_request"}, mem_read_request, 1'b0);
        check({tag, "_mem_address"}, mem_address, 32'h0);
        check({tag, "_write_enable"}, segment_write_enable, 6'b0);
        check({tag, "_load_done"}, load_done, 1'b0);
        check({tag, "_load_fault"}, load_fault, 1'b0);
        check({tag, "_fault_code"}, fault_code, 3'd0);
        check({tag, "_fault_error_code"}, fault_error_code, 16'h0);
        check({tag, "_selector_write"}, selector_write_data, 16'h0);
        check({tag, "_descriptor_write"}, descriptor_write_data, 64'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          tgt;
        logic [15:0] sel;
        bit          seen;
        reset = 1'b1; load_request = 1'b0; load_selector = 16'h0; load_target = 3'd0;
        gdtr_base = 32'h1000; gdtr_limit = 16'h00FF; ldtr_base = 32'h2000; ldtr_limit = 16'hFFFF;
        repeat (2) @(negedge clock);
        #1 check_idle_outputs("reset");
        @(negedge clock); reset = 1'b0;

        // 1: GDT code segment to CS, best-case latency.
        mem[32'h1008] = 32'h0000FFFF; mem[32'h100C] = 32'h00CF9A00;
        run_txn(16'h0008, 0, 0, 0);
        // 2: null selector to DS commits zero; to SS faults.
        run_txn(16'h0000, 2, 0, 0);
        run_txn(16'h0000, 1, 0, 0);
        // 3: selector beyond the GDT limit.
        run_txn(16'h0100, 0, 0, 0);
        // 4: LDT descriptor not present, loaded into SS.
        mem[32'h2010] = 32'h1234FFFF; mem[32'h2014] = 32'h00401200;
        run_txn(16'h0014, 1, 0, 0);
        // Limit boundary: last descriptor byte exactly at / one past the limit.
        gdtr_limit = 16'h000F; run_txn(16'h0008, 0, 1, 2);
        gdtr_limit = 16'h000E; run_txn(16'h0008, 0, 0, 0);
        gdtr_limit = 16'hFFFF; run_txn(16'hFFF8, 3, 0, 0);
        // Address wrap at the top of the 32-bit space.
        gdtr_base = 32'hFFFF_FFF8; mem[32'h0] = 32'hCAFE0000; mem[32'h4] = 32'h00009300;
        run_txn(16'h0008, 4, 0, 0);
        gdtr_base = 32'h1000; gdtr_limit = 16'h00FF;
        // 5: bus timeouts on each read, then reset during the high read.
        run_txn(16'h0008, 0, TMO, 0);
        run_txn(16'h0008, 0, 1, TMO);
        reads_allowed = 1; lat_q.push_back(0); lat_q.push_back(20); addr_q.push_back(32'h1008);
        @(negedge clock); load_selector = 16'h0008; load_target = 3'd0; load_request = 1'b1;
        @(negedge clock); load_request = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #2;
            if (mem_read_request && mem_address == 32'h100C) begin seen = 1; break; end
        end
        check("reached_read_hi", seen, 1'b1);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); #1 check_idle_outputs("mid_reset");
        @(negedge clock); reset = 1'b0; reads_allowed = 0; lat_q.delete();
        check("addr_queue_after_reset", 64'(addr_q.size()), 64'd0);
        run_txn(16'h0008, 0, 0, 0);

        // Random loads with stray mem_ready outside reads.
        spurious = 1'b1;
        for (int n = 0; n < 150; n++) begin
            gdtr_base  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255)) : $urandom;
            ldtr_base  = $urandom;
            gdtr_limit = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            ldtr_limit = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            sel = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            if ($urandom_range(0, 1) == 0) sel[15:8] = 8'h00;
            tgt = $urandom_range(0, 5);
            a = (sel[2] ? ldtr_base : gdtr_base) + {16'h0, sel[15:3], 3'b000};
            mem[a] = $urandom;
            mem[a + 32'd4] = ($urandom_range(0, 1) == 0) ? $urandom
                           : (($urandom & 32'hFFFF_0FFF) | 32'h0000_9000);
            run_txn(sel, tgt, ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 3),
                    ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 3));
        end
        spurious = 1'b0;

        repeat (3) @(negedge clock);
        check("expected_results_left", 64'(exp_q.size()), 64'd0);
        check("expected_reads_left", 64'(addr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
